cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Phase/run-control sequencer for the 8-phase VeriRisc-style CPU. It generates the 3-bit phase consumed by the instruction controller and the clock-enable that gates all CPU register loads. It provides run/stop/single-step/breakpoint control, halt-cause reporting and an instruction counter. It sits between the host/debug interface and the controller/datapath.

Parameters:
AWIDTH, 5, width of PC / breakpoint address
CNT_WIDTH, 16, width of instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin/resume free-running execution
stop  in  1  single-cycle pulse: request halt at next instruction boundary
step  in  1  single-cycle pulse: execute exactly one instruction
halt  in  1  controller halt output (asserted in phase 4 of HLT)
pc_addr  in  AWIDTH  current program counter value
bkpt_en  in  1  breakpoint enable
bkpt_addr  in  AWIDTH  breakpoint address
phase  out  3  current instruction phase 0..7 (to controller)
cpu_en  out  1  CPU register-load enable; 1 only in RUN or STEP
state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
halt_cause  out  3  0 NONE, 1 HLT, 2 BKPT, 3 STOP, 4 STEP
instr_count  out  CNT_WIDTH  completed instructions, saturating

Behaviour:
- Reset (rst_ low, asynchronous): phase=0, state=IDLE, cpu_en=0, halt_cause=0, instr_count=0, stop_pend=0. Reset asserted mid-instruction takes effect immediately; no partial completion.
- All other logic is synchronous to the rising edge of clk. cpu_en is a combinational decode of state: 1 in RUN or STEP, 0 otherwise.
- Phase: while cpu_en=1, phase increments by 1 per clk and wraps 7->0. It holds its value while cpu_en=0. In IDLE and HALT it is always 0.
- Boundary = clock edge with cpu_en=1 and phase=7.
- IDLE:
  - start -> RUN.
  - else step -> STEP.
  - stop is ignored and not latched.
  - halt_cause is unchanged.
- HALT:
  - If halt_cause=HLT, the state is sticky; start and step are ignored and only reset exits.
  - Otherwise start -> RUN and step -> STEP, with start taking priority over step.
  - Any exit from HALT clears halt_cause to 0.
  - stop and start in the same cycle: stop wins, state is unchanged.
- RUN/STEP:
  - start and step are ignored.
  - A stop pulse sets stop_pend; it is not otherwise acted on until the boundary.
  - A halt sample while phase=4 sets hlt_pend.
- At each boundary:
  - instr_count increments, saturating at all-ones.
  - Halt decision priority is HLT (hlt_pend) > BKPT (bkpt_en and pc_addr==bkpt_addr) > STOP (stop_pend, or stop asserted on the boundary cycle itself) > STEP (state==STEP).
  - If any condition holds: state -> HALT, halt_cause set to the matching code, stop_pend and hlt_pend cleared, phase becomes 0.
  - Otherwise RUN continues with phase 0.
- Breakpoint timing: pc_addr is compared on the boundary edge, so the PC holds the address of the next instruction (after the phase 6/7 inc_pc or ld_pc). Resuming from a BKPT halt executes that instruction before the next compare, so it does not re-trigger immediately.
- halt sampled outside phase 4, or while cpu_en=0, is ignored.
- No combinational path from any input to any output except state->cpu_en decode.

Test Plan:
1. Free run: reset, pulse start at cycle 0, halt=0, bkpt_en=0 -> cpu_en=1 from cycle 1; phase 0,1,..7,0,1..; after 16 enabled cycles instr_count=2, state=RUN.
2. HLT: RUN, halt=1 during phase 4 -> phase continues 5,6,7, then state=HALT, phase=0, cpu_en=0, halt_cause=1. Subsequent start and step pulses -> no change until reset.
3. Breakpoint: bkpt_en=1, bkpt_addr=5, pc_addr=5 at the boundary of the third instruction -> state=HALT, halt_cause=2, instr_count=3. Start pulse -> RUN, halt_cause=0, next instruction runs to completion.
4. Step and stop:
   - Step from IDLE -> exactly 8 enabled cycles, then HALT, halt_cause=4, instr_count=1.
   - Start, then stop pulse at phase 3 -> halts at the following boundary with halt_cause=3.
   - Stop pulse while IDLE -> ignored.
5. Reset mid-op: rst_ low at phase 5 in RUN -> phase=0, state=IDLE, cpu_en=0, instr_count=0 immediately without waiting for clk.
6. Simultaneous/saturation:
   - halt in phase 4 plus a bkpt match plus a stop pulse in the same instruction -> halt_cause=1.
   - With CNT_WIDTH=3, 9 instructions -> instr_count stays 7.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Phase and run-control sequencer for the 8-phase CPU: generates the phase
// count and register-load enable, and handles run/stop/step/breakpoint halts.
module cpu_sequencer #(
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic                 halt,
  input  logic [AWIDTH-1:0]    pc_addr,
  input  logic                 bkpt_en,
  input  logic [AWIDTH-1:0]    bkpt_addr,
  output logic [2:0]           phase,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic [2:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_HLT  = 3'd1;
  localparam logic [2:0] C_BKPT = 3'd2;
  localparam logic [2:0] C_STOP = 3'd3;
  localparam logic [2:0] C_STEP = 3'd4;

  localparam logic [2:0] PH_HLT_SAMPLE = 3'd4;
  localparam logic [2:0] PH_LAST       = 3'd7;

  logic [1:0]           state_q, state_d;
  logic [2:0]           phase_q, phase_d;
  logic [2:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 hlt_pend_q, hlt_pend_d;

  logic                 en_c;
  logic                 boundary_c;
  logic                 bkpt_hit_c;
  logic [2:0]           bnd_cause_c;

  // Halt decision evaluated at the instruction boundary, highest priority first
  always_comb begin
    en_c        = (state_q == S_RUN) || (state_q == S_STEP);
    boundary_c  = en_c && (phase_q == PH_LAST);
    bkpt_hit_c  = bkpt_en && (pc_addr == bkpt_addr);
    bnd_cause_c = C_NONE;
    if (hlt_pend_q) begin
      bnd_cause_c = C_HLT;
    end else if (bkpt_hit_c) begin
      bnd_cause_c = C_BKPT;
    end else if (stop_pend_q || stop) begin
      bnd_cause_c = C_STOP;
    end else if (state_q == S_STEP) begin
      bnd_cause_c = C_STEP;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cause_d     = cause_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    hlt_pend_d  = hlt_pend_q;

    case (state_q)
      S_IDLE: begin
        phase_d = 3'd0;
        if (start) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
      end

      S_HALT: begin
        phase_d = 3'd0;
        // An HLT instruction halt is only left through reset
        if (cause_q != C_HLT) begin
          if (start) begin
            if (!stop) begin
              state_d = S_RUN;
              cause_d = C_NONE;
            end
          end else if (step) begin
            state_d = S_STEP;
            cause_d = C_NONE;
          end
        end
      end

      default: begin
        phase_d = phase_q + 3'd1;
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (halt && (phase_q == PH_HLT_SAMPLE)) begin
          hlt_pend_d = 1'b1;
        end
        if (boundary_c) begin
          if (count_q != {CNT_WIDTH{1'b1}}) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          phase_d = 3'd0;
          if (bnd_cause_c != C_NONE) begin
            state_d     = S_HALT;
            cause_d     = bnd_cause_c;
            stop_pend_d = 1'b0;
            hlt_pend_d  = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      phase_q     <= 3'd0;
      cause_q     <= C_NONE;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      hlt_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
      hlt_pend_q  <= hlt_pend_d;
    end
  end

  assign phase       = phase_q;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign instr_count = count_q;
  // Register-load enable is a direct decode of the state register
  assign cpu_en      = (state_q == S_RUN) || (state_q == S_STEP);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random pulses,
// compared against a behavioural model; a 3-bit-counter copy checks saturation.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       start = 1'b0, stop = 1'b0, step = 1'b0, halt = 1'b0;
  logic [4:0] pc_addr = '0;
  logic       bkpt_en = 1'b0;
  logic [4:0] bkpt_addr = '0;

  logic [2:0]  phase, phase_b;
  logic        cpu_en, cpu_en_b;
  logic [1:0]  state, state_b;
  logic [2:0]  halt_cause, halt_cause_b;
  logic [15:0] instr_count;
  logic [2:0]  instr_count_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 IDLE, 1 RUN, 2 STEP, 3 HALT
  int m_state, m_phase, m_cause, m_count;
  bit m_stop_pend, m_hlt_pend;

  cpu_sequencer #(.AWIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_(rst_), .start(start), .stop(stop), .step(step), .halt(halt),
    .pc_addr(pc_addr), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .phase(phase), .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause),
    .instr_count(instr_count)
  );

  cpu_sequencer #(.AWIDTH(5), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_(rst_), .start(start), .stop(stop), .step(step), .halt(halt),
    .pc_addr(pc_addr), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .phase(phase_b), .cpu_en(cpu_en_b), .state(state_b), .halt_cause(halt_cause_b),
    .instr_count(instr_count_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_cause = 0; m_count = 0;
    m_stop_pend = 0; m_hlt_pend = 0;
  endtask

  // One rising edge of the model, using the inputs currently driven
  task automatic model_clk();
    int c;
    if (m_state == 0) begin
      if (start) m_state = 1;
      else if (step) m_state = 2;
    end else if (m_state == 3) begin
      if (m_cause != 1) begin
        if (start) begin
          if (!stop) begin m_state = 1; m_cause = 0; end
        end else if (step) begin
          m_state = 2; m_cause = 0;
        end
      end
    end else begin
      if (stop) m_stop_pend = 1;
      if (halt && m_phase == 4) m_hlt_pend = 1;
      if (m_phase == 7) begin
        m_count++;
        if (m_hlt_pend) c = 1;
        else if (bkpt_en && pc_addr == bkpt_addr) c = 2;
        else if (m_stop_pend) c = 3;
        else if (m_state == 2) c = 4;
        else c = 0;
        m_phase = 0;
        if (c != 0) begin
          m_state = 3; m_cause = c; m_stop_pend = 0; m_hlt_pend = 0;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".phase"}, int'(phase), m_phase);
    chk({where, ".cpu_en"}, int'(cpu_en), (m_state == 1 || m_state == 2) ? 1 : 0);
    chk({where, ".state"}, int'(state), m_state);
    chk({where, ".halt_cause"}, int'(halt_cause), m_cause);
    chk({where, ".instr_count"}, int'(instr_count), (m_count > 65535) ? 65535 : m_count);
    chk({where, ".instr_count_sat"}, int'(instr_count_b), (m_count > 7) ? 7 : m_count);
  endtask

  task automatic cycle(input bit st, input bit sp, input bit stp, input bit h, input string where);
    @(negedge clk);
    start = st; stop = sp; step = stp; halt = h;
    @(posedge clk);
    model_clk();
    #1;
    check_all(where);
  endtask

  task automatic do_reset(input string where);
    #3;
    rst_ = 1'b0;
    #1;
    model_reset();
    check_all(where);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  task automatic run_to_phase(input int p, input string where);
    int n = 0;
    while (m_phase != p && n < 16) begin
      cycle(0, 0, 0, 0, where);
      n++;
    end
    chk({where, ".reach_phase"}, m_phase, p);
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Stop in IDLE is ignored and not latched
    cycle(0, 1, 0, 0, "idle_stop");
    cycle(0, 0, 0, 0, "idle_stop");
    chk("idle_stop.state", int'(state), 0);

    // Free run: 16 enabled cycles complete two instructions
    cycle(1, 0, 0, 0, "run_start");
    chk("run_start.cpu_en", int'(cpu_en), 1);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, "free_run");
    chk("free_run.count", int'(instr_count), 2);
    chk("free_run.state", int'(state), 1);

    // Stop at phase 3 halts at the following boundary
    run_to_phase(3, "stop_run");
    cycle(0, 1, 0, 0, "stop_pulse");
    run_to_phase(7, "stop_run");
    cycle(0, 0, 0, 0, "stop_bnd");
    chk("stop_bnd.cause", int'(halt_cause), 3);

    // Breakpoint at the third boundary, then resume runs the next instruction
    do_reset("reset_bkpt");
    bkpt_en = 1'b1; bkpt_addr = 5'd5; pc_addr = 5'd0;
    cycle(1, 0, 0, 0, "bkpt_start");
    for (int i = 0; i < 23; i++) cycle(0, 0, 0, 0, "bkpt_run");
    pc_addr = 5'd5;
    cycle(0, 0, 0, 0, "bkpt_bnd");
    chk("bkpt_bnd.state", int'(state), 3);
    chk("bkpt_bnd.cause", int'(halt_cause), 2);
    chk("bkpt_bnd.count", int'(instr_count), 3);
    pc_addr = 5'd6;
    cycle(1, 1, 0, 0, "bkpt_stop_start");
    chk("bkpt_stop_start.state", int'(state), 3);
    cycle(1, 0, 0, 0, "bkpt_resume");
    chk("bkpt_resume.cause", int'(halt_cause), 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, "bkpt_next");
    chk("bkpt_next.count", int'(instr_count), 4);
    bkpt_en = 1'b0;

    // Single step from IDLE, then step again from the STEP halt
    do_reset("reset_step");
    cycle(0, 0, 1, 0, "step_go");
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, "step_run");
    chk("step.state", int'(state), 3);
    chk("step.cause", int'(halt_cause), 4);
    chk("step.count", int'(instr_count), 1);
    cycle(0, 0, 1, 0, "step_again");
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, "step_again");

    // HLT beats a breakpoint match and a pending stop; then it is sticky
    do_reset("reset_hlt");
    bkpt_en = 1'b1; bkpt_addr = 5'd5; pc_addr = 5'd0;
    cycle(1, 0, 0, 0, "hlt_start");
    run_to_phase(2, "hlt_run");
    cycle(0, 1, 0, 0, "hlt_stop");
    run_to_phase(4, "hlt_run");
    cycle(0, 0, 0, 1, "hlt_sample");
    run_to_phase(7, "hlt_run");
    pc_addr = 5'd5;
    cycle(0, 0, 0, 0, "hlt_bnd");
    chk("hlt_bnd.cause", int'(halt_cause), 1);
    chk("hlt_bnd.state", int'(state), 3);
    cycle(1, 0, 0, 0, "hlt_sticky_start");
    cycle(0, 0, 1, 0, "hlt_sticky_step");
    cycle(1, 0, 1, 0, "hlt_sticky_both");
    chk("hlt_sticky.state", int'(state), 3);
    bkpt_en = 1'b0; pc_addr = 5'd0;

    // Halt outside phase 4 is ignored; reset at phase 5 acts immediately
    do_reset("reset_mid");
    cycle(1, 0, 0, 0, "mid_start");
    cycle(0, 0, 0, 1, "mid_halt_ph0");
    run_to_phase(5, "mid_run");
    do_reset("reset_async");
    chk("reset_async.state", int'(state), 0);

    // Long free run for counter saturation of the 3-bit copy
    cycle(1, 0, 0, 0, "sat_start");
    for (int i = 0; i < 80; i++) cycle(0, 0, 0, 0, "sat_run");
    chk("sat.count_b", int'(instr_count_b), 7);

    // Random pulses and PC values against the model
    for (int i = 0; i < 3000; i++) begin
      pc_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) bkpt_en = ~bkpt_en;
      if ($urandom_range(0, 199) == 0) bkpt_addr = 5'($urandom_range(0, 31));
      if (m_state == 3 && m_cause == 1 && $urandom_range(0, 15) == 0) begin
        do_reset("rand_reset");
      end else begin
        cycle($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
